// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer
// Drives the t inputs of an external bank of T flip-flops so that the bank
// is cleared and then counts up to a captured limit, then pulses done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, t_out=0
// CLEAR | one cycle, t_out=q_in so every set flop toggles to 0
// RUN   | binary increment of the bank until it equals limit_q
// DONE  | one-cycle done pulse, bank holds the limit value
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] inc_t;
  logic             carry;

  // Toggle pattern that advances the bank by one: bit i flips when all lower bits are set.
  always_comb begin
    inc_t = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_t[i] = carry;
      carry    = carry & q_in[i];
    end
  end

  // Next-state and limit capture; abort wins over everything while busy.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          limit_d = limit;
        end
      end
      CLEAR: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort)                state_d = IDLE;
        else if (q_in == limit_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank toggle drive; terminal match is checked before pause so a paused
  // bank sitting on its limit still finishes.
  always_comb begin
    t_out = '0;
    case (state_q)
      CLEAR: if (!abort) t_out = q_in;
      RUN: begin
        if (!abort && (q_in != limit_q) && !pause) t_out = inc_t;
      end
      default: t_out = '0;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == CLEAR) || (state_q == RUN);
    done = (state_q == DONE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Testbench for tff_count_sequencer with a behavioural 4-bit T flip-flop bank.
module tb_tff_count_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] limit;
  logic       pause;
  logic       abort;
  logic [3:0] q_in;
  logic [3:0] t_out;
  logic       busy;
  logic       done;

  logic       load_en;
  logic [3:0] load_val;

  int n_cmp = 0;
  int n_err = 0;

  tff_count_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .limit (limit),
    .pause (pause),
    .abort (abort),
    .q_in  (q_in),
    .t_out (t_out),
    .busy  (busy),
    .done  (done)
  );

  always #50 clk = ~clk;

  // T flip-flop bank; load_en lets the bench preload it directly.
  always @(posedge clk) begin
    if (reset)        q_in <= 4'd0;
    else if (load_en) q_in <= load_val;
    else              q_in <= q_in ^ t_out;
  end

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; limit = 4'd0; pause = 1'b0; abort = 1'b0;
    load_en = 1'b0; load_val = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({t_out, busy, done, q_in} !== 10'd0) begin
      n_err++;
      $display("FAIL reset: t_out=%b busy=%b done=%b q_in=%b required all 0", t_out, busy, done, q_in);
    end
    reset = 1'b0;
  endtask

  // Full run from start to done; optionally preload the bank with a junk value first.
  task automatic test_count(input logic [3:0] lim, input logic preload, input logic [3:0] pre);
    logic [3:0] kv;
    logic [3:0] exp_t;
    if (preload) begin
      load_en = 1'b1; load_val = pre;
      @(negedge clk);
      load_en = 1'b0;
      n_cmp++;
      if (q_in !== pre) begin
        n_err++; $display("FAIL preload: q_in=%b required %b", q_in, pre);
      end
    end
    start = 1'b1; limit = lim;
    @(negedge clk);
    start = 1'b0; limit = 4'd2;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || t_out !== q_in) begin
      n_err++;
      $display("FAIL clear lim=%0d: busy=%b done=%b t_out=%b q_in=%b required busy=1 t_out=q_in", lim, busy, done, t_out, q_in);
    end
    for (int k = 0; k <= int'(lim); k++) begin
      @(negedge clk);
      kv    = 4'(k);
      exp_t = (kv == lim) ? 4'd0 : (kv ^ (kv + 4'd1));
      n_cmp++;
      if (q_in !== kv || t_out !== exp_t || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL run lim=%0d step=%0d: q_in=%b t_out=%b busy=%b done=%b required q_in=%b t_out=%b busy=1 done=0",
                 lim, k, q_in, t_out, busy, done, kv, exp_t);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || q_in !== lim || t_out !== 4'd0) begin
      n_err++;
      $display("FAIL done lim=%0d: done=%b busy=%b q_in=%b t_out=%b required done=1 busy=0 q_in=%b t_out=0", lim, done, busy, q_in, t_out, lim);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || q_in !== lim) begin
      n_err++;
      $display("FAIL after_done lim=%0d: done=%b busy=%b q_in=%b required done=0 busy=0 q_in=%b", lim, done, busy, q_in, lim);
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp_q [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6};
    logic       pz    [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_t;
    start = 1'b1; limit = 4'd6;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b1;
    n_cmp++;
    if (t_out !== q_in || busy !== 1'b1) begin
      n_err++; $display("FAIL pause_clear: t_out=%b q_in=%b busy=%b required t_out=q_in busy=1", t_out, q_in, busy);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pause = pz[k];
      #1;
      exp_t = (pz[k] || exp_q[k] == 4'd6) ? 4'd0 : (exp_q[k] ^ (exp_q[k] + 4'd1));
      n_cmp++;
      if (q_in !== exp_q[k] || t_out !== exp_t || done !== 1'b0) begin
        n_err++;
        $display("FAIL pause step=%0d: q_in=%b t_out=%b done=%b required q_in=%b t_out=%b done=0", k, q_in, t_out, done, exp_q[k], exp_t);
      end
    end
    pause = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || q_in !== 4'd6) begin
      n_err++; $display("FAIL pause_done: done=%b q_in=%b required done=1 q_in=0110", done, q_in);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; limit = 4'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // q=0: a start with a new limit while busy must not be taken
    start = 1'b1; limit = 4'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (q_in !== 4'd1 || t_out !== 4'b0011 || busy !== 1'b1) begin
      n_err++; $display("FAIL start_ignored: q_in=%b t_out=%b busy=%b required q_in=0001 t_out=0011 busy=1", q_in, t_out, busy);
    end
    @(negedge clk);
    abort = 1'b1;
    #1;
    n_cmp++;
    if (q_in !== 4'd2 || t_out !== 4'd0) begin
      n_err++; $display("FAIL abort_cycle: q_in=%b t_out=%b required q_in=0010 t_out=0000", q_in, t_out);
    end
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || q_in !== 4'd2 || t_out !== 4'd0) begin
        n_err++;
        $display("FAIL after_abort cyc=%0d: busy=%b done=%b q_in=%b t_out=%b required busy=0 done=0 q_in=0010 t_out=0", k, busy, done, q_in, t_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; limit = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (q_in !== 4'd4 || busy !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: q_in=%b busy=%b required q_in=0100 busy=1", q_in, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (q_in !== 4'd0 || busy !== 1'b0 || t_out !== 4'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: q_in=%b busy=%b t_out=%b done=%b required all 0", q_in, busy, t_out, done);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL post_reset: done=%b busy=%b required 0", done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_count(4'd5, 1'b1, 4'b1011);
    test_count(4'd0, 1'b0, 4'd0);
    test_count(4'd15, 1'b0, 4'd0);
    test_pause();
    @(negedge clk);
    test_abort();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
